// File: rtl/quad_updown_decoder_pkg.sv
// Shared phase encodings, limits and the prev/cur transition classifier
// for the quadrature up/down decoder.
package quad_updown_decoder_pkg;

  localparam int CW_DEF = 4;
  localparam logic [1:0] FILL_MAX = 2'd3;

  // Phase state is {A,B}; the up direction walks 00 -> 01 -> 11 -> 10 -> 00.
  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_t;

  typedef enum logic [1:0] {
    MV_NONE,
    MV_UP,
    MV_DOWN,
    MV_ILLEGAL
  } move_t;

  function automatic logic [1:0] next_up(input logic [1:0] ph);
    logic [1:0] nu;
    nu = PH_00;
    case (ph)
      PH_00:   nu = PH_01;
      PH_01:   nu = PH_11;
      PH_11:   nu = PH_10;
      PH_10:   nu = PH_00;
      default: nu = PH_00;
    endcase
    return nu;
  endfunction

  function automatic move_t decode_move(input logic [1:0] prev, input logic [1:0] cur);
    move_t mv;
    if (prev == cur) begin
      mv = MV_NONE;
    end else if (cur == next_up(prev)) begin
      mv = MV_UP;
    end else if (prev == next_up(cur)) begin
      mv = MV_DOWN;
    end else begin
      mv = MV_ILLEGAL;
    end
    return mv;
  endfunction

endpackage

// File: rtl/quad_updown_decoder_sync2.sv
// Two-flop synchronizer with synchronous reset for one asynchronous input.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/quad_updown_decoder.sv
// Quadrature decoder: synchronizes A/B, classifies each phase transition and
// keeps a modulo-2^CW position count with step/wrap/err pulses.
module quad_updown_decoder
  import quad_updown_decoder_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_in,
  input  logic          b_in,
  input  logic          clr,
  output logic [CW-1:0] q,
  output logic          up_down,
  output logic          step,
  output logic          wrap,
  output logic          err,
  output logic          err_sticky
);

  localparam logic [CW-1:0] Q_MAX = '1;
  localparam logic [CW-1:0] Q_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0] raw;
  logic [1:0] cur;
  logic [1:0] prev;
  logic [1:0] fill;
  move_t      move;

  assign raw = {a_in, b_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw[gi]),
        .q   (cur[gi])
      );
    end
  endgenerate

  // Until the synchronizer and prev have been refilled after reset, their
  // contents are stale zeros and must not be interpreted as movement.
  always_comb begin
    move = MV_NONE;
    if (fill == FILL_MAX) begin
      move = decode_move(prev, cur);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= 2'b00;
      fill       <= 2'd0;
      q          <= '0;
      up_down    <= 1'b0;
      step       <= 1'b0;
      wrap       <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      prev <= cur;
      if (fill != FILL_MAX) begin
        fill <= fill + 2'd1;
      end
      step <= 1'b0;
      wrap <= 1'b0;
      err  <= 1'b0;
      case (move)
        MV_UP: begin
          step    <= 1'b1;
          up_down <= 1'b0;
          if (!clr) begin
            q    <= q + Q_ONE;
            wrap <= (q == Q_MAX);
          end
        end
        MV_DOWN: begin
          step    <= 1'b1;
          up_down <= 1'b1;
          if (!clr) begin
            q    <= q - Q_ONE;
            wrap <= (q == '0);
          end
        end
        MV_ILLEGAL: begin
          err        <= 1'b1;
          err_sticky <= 1'b1;
        end
        default: ;
      endcase
      // Clear wins over any count or sticky update made above this cycle.
      if (clr) begin
        q          <= '0;
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_updown_decoder.sv
// Scoreboard bench: stimulus pushes expected pulses, a negedge monitor pops
// and checks them whenever step or err is seen.
module tb_quad_updown_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] q;
  logic       up_down;
  logic       step;
  logic       wrap;
  logic       err;
  logic       err_sticky;

  quad_updown_decoder #(.CW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_in       (a_in),
    .b_in       (b_in),
    .clr        (clr),
    .q          (q),
    .up_down    (up_down),
    .step       (step),
    .wrap       (wrap),
    .err        (err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    bit         is_err;
    logic [3:0] q;
    logic       ud;
    logic       wr;
    logic       st;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (step || err) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got step=%0b err=%0b expected none (cycle %0d)", step, err, cyc);
      end else begin
        e = sbq.pop_front();
        $display("pulse cycle=%0d step=%0b err=%0b q=%0d up_down=%0b wrap=%0b sticky=%0b",
                 cyc, step, err, q, up_down, wrap, err_sticky);
        chk("pulse_cycle", cyc, e.at);
        chk("pulse_err", {31'd0, err}, {31'd0, e.is_err});
        chk("pulse_step", {31'd0, step}, {31'd0, !e.is_err});
        chk("pulse_q", {28'd0, q}, {28'd0, e.q});
        chk("pulse_up_down", {31'd0, up_down}, {31'd0, e.ud});
        chk("pulse_wrap", {31'd0, wrap}, {31'd0, e.wr});
        chk("pulse_sticky", {31'd0, err_sticky}, {31'd0, e.st});
      end
    end else if (wrap) begin
      chk("wrap_without_step", {31'd0, wrap}, 32'd0);
    end
  end

  // kind: 0 = no pulse, 1 = step, 2 = err; each phase is held 4 cycles.
  task automatic phase(input logic [1:0] ab, input int kind, input logic [3:0] eq,
                       input logic eud, input logic ewr, input logic est);
    @(negedge clk);
    {a_in, b_in} = ab;
    if (kind != 0) sbq.push_back('{cyc + 3, kind == 2, eq, eud, ewr, est});
    repeat (3) @(negedge clk);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // clr is raised so that it is high on exactly the edge that decodes ab.
  task automatic clr_coincide(input logic [1:0] ab, input bit is_err);
    @(negedge clk);
    {a_in, b_in} = ab;
    sbq.push_back('{cyc + 3, is_err, 4'd0, 1'b0, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_q"}, {28'd0, q}, 32'd0);
    chk({tag, "_up_down"}, {31'd0, up_down}, 32'd0);
    chk({tag, "_step"}, {31'd0, step}, 32'd0);
    chk({tag, "_wrap"}, {31'd0, wrap}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_sticky"}, {31'd0, err_sticky}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Up sequence from reset.
    phase(2'b01, 1, 4'd1, 1'b0, 1'b0, 1'b0);
    phase(2'b11, 1, 4'd2, 1'b0, 1'b0, 1'b0);
    phase(2'b10, 1, 4'd3, 1'b0, 1'b0, 1'b0);
    phase(2'b00, 1, 4'd4, 1'b0, 1'b0, 1'b0);

    clr_pulse();
    chk("clr_q", {28'd0, q}, 32'd0);

    // Down through zero with wrap.
    phase(2'b01, 1, 4'd1, 1'b0, 1'b0, 1'b0);
    phase(2'b00, 1, 4'd0, 1'b1, 1'b0, 1'b0);
    phase(2'b10, 1, 4'd15, 1'b1, 1'b1, 1'b0);
    phase(2'b11, 1, 4'd14, 1'b1, 1'b0, 1'b0);
    phase(2'b01, 1, 4'd13, 1'b1, 1'b0, 1'b0);
    phase(2'b00, 1, 4'd12, 1'b1, 1'b0, 1'b0);

    // Illegal jump 00 -> 11.
    phase(2'b11, 2, 4'd12, 1'b1, 1'b0, 1'b1);
    chk("illegal_q_held", {28'd0, q}, 32'd12);
    chk("illegal_sticky_held", {31'd0, err_sticky}, 32'd1);
    clr_pulse();
    chk("clr2_q", {28'd0, q}, 32'd0);
    chk("clr2_sticky", {31'd0, err_sticky}, 32'd0);

    // Reach 15, then clr coincident with an up step, then with an illegal step.
    phase(2'b01, 1, 4'd15, 1'b1, 1'b1, 1'b0);
    clr_coincide(2'b11, 1'b0);
    clr_coincide(2'b00, 1'b1);
    chk("clr_err_sticky", {31'd0, err_sticky}, 32'd0);

    // Build non-zero state, then reset between an input change and its effect.
    phase(2'b10, 1, 4'd15, 1'b1, 1'b1, 1'b0);
    phase(2'b11, 1, 4'd14, 1'b1, 1'b0, 1'b0);
    phase(2'b00, 2, 4'd14, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    {a_in, b_in} = 2'b01;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midrst");
    repeat (6) @(negedge clk);
    chk("midrst_q_later", {28'd0, q}, 32'd0);

    // Inputs at 11 through reset release must not count.
    @(negedge clk);
    rst = 1'b1;
    {a_in, b_in} = 2'b11;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rel_step", {31'd0, step}, 32'd0);
      chk("rel_err", {31'd0, err}, 32'd0);
      chk("rel_q", {28'd0, q}, 32'd0);
    end
    repeat (3) @(negedge clk);
    phase(2'b10, 1, 4'd1, 1'b0, 1'b0, 1'b0);
    phase(2'b00, 1, 4'd2, 1'b0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
